bus_source_arbiter: RTL and testbench
=====================================

BUS_SOURCE_ARBITER -- requirements
Module: bus_source_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max DRIVE cycles without bus_ack before abort; legal range 1..255.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-source transfer request, bit i = source i; level-sensitive.
REQ-005 src_data0..src_data3  input  8 each  source register contents.
REQ-006 bus_ack  input  1  consumer register has loaded bus_out this cycle.
REQ-007 bus_out  output  8  registered bus data.
REQ-008 bus_valid  output  1  bus_out holds a granted source's data.
REQ-009 grant  output  4  one-hot registered grant, all-zero when idle.
REQ-010 timeout_err  output  1  sticky flag, set on abort.

Function
REQ-011 FSM states SHALL be IDLE and DRIVE only.
REQ-012 IDLE with req != 0: next edge SHALL select the winner by round-robin from priority pointer ptr, latch src_data[winner] into bus_out, set grant[winner], assert bus_valid, enter DRIVE.
REQ-013 Round-robin: search order ptr, ptr+1, ..., ptr+3 mod 4; first requesting index wins.
REQ-014 IDLE with req == 0: bus_valid=0, grant=0, bus_out holds its last value.
REQ-015 DRIVE: bus_out and grant SHALL stay stable regardless of src_data or req changes.
REQ-016 DRIVE with bus_ack=1: transfer completes that edge; ptr <= winner+1 mod 4.
REQ-017 Completion with another req bit set (excluding the just-served winner's bit): SHALL grant the next round-robin winner on the same edge, staying in DRIVE (back-to-back, 1 transfer/cycle peak).
REQ-018 Completion with only the just-served source still requesting: that source SHALL be re-granted on the same edge.
REQ-019 Completion with req == 0: go IDLE, bus_valid=0, grant=0.
REQ-020 Dropping req of the granted source during DRIVE SHALL NOT cancel the transfer.
REQ-021 Wait counter SHALL clear on each grant and increment each DRIVE cycle without bus_ack.
REQ-022 Counter reaching TIMEOUT without bus_ack: abort on that edge: timeout_err <= 1, ptr <= winner+1, go IDLE, bus_valid=0, grant=0.
REQ-023 bus_ack on the same cycle as the counter limit: completion SHALL take precedence over abort.
REQ-024 bus_ack in IDLE SHALL be ignored.
REQ-025 timeout_err SHALL be cleared only by clear.
REQ-026 Latency: req asserted in cycle N (IDLE) -> bus_valid in cycle N+1.

Reset
REQ-027 clear=1 at a rising edge SHALL force IDLE, bus_out=8'h00, bus_valid=0, grant=4'b0000, ptr=0, wait counter=0, timeout_err=0.
REQ-028 clear SHALL override all other inputs, including mid-DRIVE; no transfer completes on that edge.
REQ-029 First cycle after clear deasserts SHALL behave as IDLE.

Verification
REQ-030 Single req: clear, req=4'b0100, src_data2=8'hA5 -> next cycle grant=4'b0100, bus_valid=1, bus_out=8'hA5; bus_ack=1 for one cycle -> IDLE, bus_valid=0.
REQ-031 Round-robin: req=4'b1111 held, bus_ack=1 every cycle from ptr=0 -> grant sequence 0001, 0010, 0100, 1000, 0001, bus_valid continuously 1.
REQ-032 Stability: granted src 1 (8'h3C), src_data1 changes to 8'hFF during DRIVE with bus_ack=0 -> bus_out remains 8'h3C until ack.
REQ-033 Timeout: TIMEOUT=15, grant src 3, bus_ack never asserted -> after 15 DRIVE cycles bus_valid=0, grant=0, timeout_err=1, ptr=0; timeout_err stays 1 until clear.
REQ-034 Ack on limit: bus_ack=1 exactly on the 15th DRIVE cycle -> normal completion, timeout_err stays 0.
REQ-035 Reset mid-transfer: clear during DRIVE with req=4'b0011 -> next cycle all outputs at reset values; after clear deasserts, src 0 granted first.

Source files
------------

// File: rtl/bus_source_arbiter.sv
// -----------------------------------------------------------------------------
// bus_source_arbiter
//
// Round-robin arbiter that moves one of four 8-bit source registers onto a
// shared, registered bus. A winner is latched into bus_out and held stable
// until the consumer acknowledges it (bus_ack) or until the wait limit
// TIMEOUT expires. On an abort, the sticky flag timeout_err is set.
// Completion can re-grant on the same edge, which gives one transfer per
// cycle when acks arrive back to back.
//
// Ports
//   clk          : sole clock, rising edge
//   clear        : synchronous active-high reset
//   req[3:0]     : level-sensitive request, bit i = source i
//   src_data0..3 : source register contents
//   bus_ack      : consumer loaded bus_out this cycle (ignored when idle)
//   bus_out[7:0] : registered bus data
//   bus_valid    : bus_out holds a granted source's data
//   grant[3:0]   : one-hot registered grant, zero when idle
//   timeout_err  : sticky abort flag, cleared only by clear
// -----------------------------------------------------------------------------
module bus_source_arbiter #(
    parameter int unsigned TIMEOUT = 15   // legal range 1..255
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] req,
    input  logic [7:0] src_data0,
    input  logic [7:0] src_data1,
    input  logic [7:0] src_data2,
    input  logic [7:0] src_data3,
    input  logic       bus_ack,
    output logic [7:0] bus_out,
    output logic       bus_valid,
    output logic [3:0] grant,
    output logic       timeout_err
);

    typedef enum logic {IDLE, DRIVE} state_t;

    // Value the wait counter holds during the last DRIVE cycle allowed.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win_q, win_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       terr_q, terr_d;

    logic [1:0] pick;
    logic [1:0] ptr_next;

    // First requesting index in the order p, p+1, p+2, p+3 (mod 4).
    // Scanning from the far end down lets the closest hit overwrite.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) sel = idx;
        end
        return sel;
    endfunction

    function automatic logic [7:0] src_sel(input logic [1:0] s,
                                           input logic [7:0] d0, input logic [7:0] d1,
                                           input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] v;
        case (s)
            2'd0:    v = d0;
            2'd1:    v = d1;
            2'd2:    v = d2;
            default: v = d3;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        bus_out_d = bus_out_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        terr_d    = terr_q;
        ptr_next  = win_q + 2'd1;
        pick      = rr_pick(req, ptr_q);

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                grant_d = 4'b0000;
                if (req != 4'b0000) begin
                    win_d     = pick;
                    bus_out_d = src_sel(pick, src_data0, src_data1, src_data2, src_data3);
                    grant_d   = 4'b0001 << pick;
                    valid_d   = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                if (bus_ack) begin
                    // Searching from winner+1 puts the just-served source last,
                    // so it is re-granted only when nobody else is requesting.
                    ptr_d = ptr_next;
                    pick  = rr_pick(req, ptr_next);
                    if (req != 4'b0000) begin
                        win_d     = pick;
                        bus_out_d = src_sel(pick, src_data0, src_data1, src_data2, src_data3);
                        grant_d   = 4'b0001 << pick;
                        valid_d   = 1'b1;
                        cnt_d     = 8'd0;
                    end else begin
                        valid_d = 1'b0;
                        grant_d = 4'b0000;
                        state_d = IDLE;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    terr_d  = 1'b1;
                    ptr_d   = ptr_next;
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            win_q     <= 2'd0;
            cnt_q     <= 8'd0;
            bus_out_q <= 8'h00;
            grant_q   <= 4'b0000;
            valid_q   <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            bus_out_q <= bus_out_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            terr_q    <= terr_d;
        end
    end

    assign bus_out     = bus_out_q;
    assign bus_valid   = valid_q;
    assign grant       = grant_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
module tb_bus_source_arbiter;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] req;
    logic [7:0] src_data0, src_data1, src_data2, src_data3;
    logic       bus_ack;
    logic [7:0] bus_out;
    logic       bus_valid;
    logic [3:0] grant;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    bus_source_arbiter #(.TIMEOUT(15)) dut (
        .clk         (clk),
        .clear       (clear),
        .req         (req),
        .src_data0   (src_data0),
        .src_data1   (src_data1),
        .src_data2   (src_data2),
        .src_data3   (src_data3),
        .bus_ack     (bus_ack),
        .bus_out     (bus_out),
        .bus_valid   (bus_valid),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] g, input logic v, input logic [7:0] d);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".valid"}, 32'(bus_valid), 32'(v));
        check({tag, ".data"}, 32'(bus_out), 32'(d));
    endtask

    initial begin
        clear = 1'b1; req = 4'b0000; bus_ack = 1'b0;
        src_data0 = 8'h11; src_data1 = 8'h22; src_data2 = 8'h33; src_data3 = 8'h44;

        // Reset state
        tick();
        chk_bus("reset", 4'b0000, 1'b0, 8'h00);
        check("reset.terr", 32'(timeout_err), 32'd0);
        clear = 1'b0;

        // Single request, one-cycle latency, ack completes to idle
        src_data2 = 8'hA5; req = 4'b0100;
        tick();
        chk_bus("single.grant", 4'b0100, 1'b1, 8'hA5);
        req = 4'b0000; bus_ack = 1'b1;
        tick();
        chk_bus("single.done", 4'b0000, 1'b0, 8'hA5);

        // Ack while idle does nothing
        tick();
        chk_bus("idle.ack", 4'b0000, 1'b0, 8'hA5);
        bus_ack = 1'b0;

        // Round robin from ptr=0 with continuous ack
        clear = 1'b1; src_data2 = 8'h33;
        tick();
        clear = 1'b0; req = 4'b1111;
        tick();
        chk_bus("rr0", 4'b0001, 1'b1, 8'h11);
        bus_ack = 1'b1;
        tick(); chk_bus("rr1", 4'b0010, 1'b1, 8'h22);
        tick(); chk_bus("rr2", 4'b0100, 1'b1, 8'h33);
        tick(); chk_bus("rr3", 4'b1000, 1'b1, 8'h44);
        tick(); chk_bus("rr4", 4'b0001, 1'b1, 8'h11);
        req = 4'b0000;
        tick(); chk_bus("rr.idle", 4'b0000, 1'b0, 8'h11);   // ptr now 1
        bus_ack = 1'b0;

        // Only the served source still requesting: re-granted same edge
        req = 4'b0010;
        tick(); chk_bus("regrant.a", 4'b0010, 1'b1, 8'h22);
        bus_ack = 1'b1;
        tick(); chk_bus("regrant.b", 4'b0010, 1'b1, 8'h22);
        req = 4'b0000;
        tick(); chk_bus("regrant.idle", 4'b0000, 1'b0, 8'h22);  // ptr now 2
        bus_ack = 1'b0;

        // Stability during DRIVE
        src_data1 = 8'h3C; req = 4'b0010;
        tick(); chk_bus("stab.grant", 4'b0010, 1'b1, 8'h3C);
        src_data1 = 8'hFF; req = 4'b1111;
        tick(); chk_bus("stab.hold1", 4'b0010, 1'b1, 8'h3C);
        tick(); chk_bus("stab.hold2", 4'b0010, 1'b1, 8'h3C);
        bus_ack = 1'b1; req = 4'b0000;
        tick(); chk_bus("stab.done", 4'b0000, 1'b0, 8'h3C);  // ptr now 2
        bus_ack = 1'b0;

        // Timeout on source 3; its req dropped mid-transfer
        req = 4'b1000;
        tick(); chk_bus("to.grant", 4'b1000, 1'b1, 8'h44);
        req = 4'b0000;
        for (int i = 0; i < 14; i++) tick();
        chk_bus("to.cycle14", 4'b1000, 1'b1, 8'h44);
        check("to.terr14", 32'(timeout_err), 32'd0);
        tick();
        chk_bus("to.abort", 4'b0000, 1'b0, 8'h44);
        check("to.terr", 32'(timeout_err), 32'd1);
        req = 4'b1111;                                        // ptr must be 0
        tick(); chk_bus("to.ptr", 4'b0001, 1'b1, 8'h11);
        check("to.sticky1", 32'(timeout_err), 32'd1);
        bus_ack = 1'b1; req = 4'b0000;
        tick(); check("to.sticky2", 32'(timeout_err), 32'd1);
        bus_ack = 1'b0;

        // Ack exactly on the limit cycle completes normally
        clear = 1'b1;
        tick(); check("clr.terr", 32'(timeout_err), 32'd0);
        clear = 1'b0; req = 4'b0100;
        tick(); chk_bus("lim.grant", 4'b0100, 1'b1, 8'h33);
        req = 4'b0000;
        for (int i = 0; i < 14; i++) tick();
        chk_bus("lim.cycle14", 4'b0100, 1'b1, 8'h33);
        bus_ack = 1'b1;
        tick();
        chk_bus("lim.done", 4'b0000, 1'b0, 8'h33);
        check("lim.terr", 32'(timeout_err), 32'd0);
        bus_ack = 1'b0;                                       // ptr now 3

        // Clear mid-transfer overrides completion and restores ptr=0
        req = 4'b0001;
        tick(); chk_bus("mid.grant", 4'b0001, 1'b1, 8'h11);
        req = 4'b0011; bus_ack = 1'b1; clear = 1'b1;
        tick(); chk_bus("mid.clear", 4'b0000, 1'b0, 8'h00);
        clear = 1'b0; bus_ack = 1'b0;
        tick(); chk_bus("mid.after", 4'b0001, 1'b1, 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
